// File: rtl/clb_pipe_pkg.sv
// Shared types and helpers for the pipelined CLB array: ALU op codes,
// the per-cell configuration record and configuration width helpers.
package clb_pipe_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_AND = 2'b10,
        OP_XOR = 2'b11
    } op_e;

    // Select fields are stored at a fixed maximum width; only the low
    // sel_w(ROWS) bits are ever written, the rest stay zero.
    localparam int unsigned SEL_MAXW = 8;
    localparam int unsigned CFG_MAXW = 2 * SEL_MAXW + 3;

    typedef struct packed {
        logic                bypass;
        op_e                 op;
        logic [SEL_MAXW-1:0] sel1;
        logic [SEL_MAXW-1:0] sel0;
    } cell_cfg_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } commit_state_e;

    function automatic int unsigned sel_w(input int unsigned rows);
        return $clog2(2 * rows);
    endfunction

    function automatic int unsigned cfg_w(input int unsigned rows);
        return 2 * sel_w(rows) + 3;
    endfunction

    // Split a raw {bypass, op, sel1, sel0} word whose select fields are selw bits wide.
    function automatic cell_cfg_t cell_cfg_unpack(input logic [CFG_MAXW-1:0] raw,
                                                  input int unsigned selw);
        cell_cfg_t           cfg;
        logic [SEL_MAXW-1:0] mask;
        mask       = (SEL_MAXW'(1) << selw) - SEL_MAXW'(1);
        cfg.sel0   = raw[SEL_MAXW-1:0] & mask;
        cfg.sel1   = SEL_MAXW'(raw >> selw) & mask;
        cfg.op     = op_e'(2'(raw >> (2 * selw)));
        cfg.bypass = 1'(raw >> (2 * selw + 2));
        return cfg;
    endfunction

endpackage

// File: rtl/clb_pipe_cell.sv
// One ALU cell: two operand muxes over NSRC sources followed by a
// modulo-2^WIDTH ADD/SUB/AND/XOR and an optional pass-through of operand a.
module clb_pipe_cell
    import clb_pipe_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned NSRC  = 8,
    localparam int unsigned IDXW  = $clog2(NSRC)
) (
    input  logic [NSRC*WIDTH-1:0] src,
    input  logic [IDXW-1:0]       sel0,
    input  logic [IDXW-1:0]       sel1,
    input  logic                  bypass,
    input  logic [1:0]            op,
    output logic [WIDTH-1:0]      y
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] alu;

    // Operand select, ALU and bypass; NSRC is a power of two so the index never overruns.
    always_comb begin
        a = WIDTH'(src >> (WIDTH * sel0));
        b = WIDTH'(src >> (WIDTH * sel1));
        case (op_e'(op))
            OP_ADD:  alu = a + b;
            OP_SUB:  alu = a - b;
            OP_AND:  alu = a & b;
            default: alu = a ^ b;
        endcase
        y = bypass ? a : alu;
    end

endmodule

// File: rtl/clb_pipe_array.sv
// ROWS x COLS grid of ALU cells, one register stage per column, with a
// stream handshake and a double-buffered configuration that is only
// committed once the pipeline is empty.
//
// Handshake: a beat enters when in_valid & in_ready at the clock edge and
// leaves when res_valid & res_ready at the edge. While res_valid & ~res_ready
// every stage holds, so res_data stays stable; in_ready drops while stalled
// or while a commit is pending.
module clb_pipe_array
    import clb_pipe_pkg::*;
#(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned ROWS  = 4,
    parameter  int unsigned COLS  = 4,
    parameter  int unsigned NRES  = 3,
    localparam int unsigned NIN   = 2 * ROWS,
    localparam int unsigned SELW  = sel_w(ROWS),
    localparam int unsigned CFGW  = cfg_w(ROWS),
    localparam int unsigned ADDRW = $clog2(ROWS * COLS + NRES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NIN*WIDTH-1:0]  in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [NRES*WIDTH-1:0] res_data,
    output logic                  res_valid,
    input  logic                  res_ready,
    input  logic                  cfg_we,
    input  logic [ADDRW-1:0]      cfg_addr,
    input  logic [CFGW-1:0]       cfg_data,
    input  logic                  cfg_commit,
    output logic                  cfg_busy,
    output logic                  dbg_state
);

    localparam int unsigned RSW   = $clog2(ROWS);
    localparam int unsigned NCELL = ROWS * COLS;

    logic [ROWS*WIDTH-1:0] stage_data_q [COLS];
    logic [ROWS*WIDTH-1:0] stage_data_d [COLS];
    logic [COLS-1:0]       stage_vld_q;
    logic [COLS-1:0]       stage_vld_d;
    logic [ROWS*WIDTH-1:0] col_out [COLS];
    logic [WIDTH-1:0]      cell_y [COLS][ROWS];

    cell_cfg_t             shadow_cell_q [NCELL];
    cell_cfg_t             shadow_cell_d [NCELL];
    cell_cfg_t             active_cell_q [NCELL];
    cell_cfg_t             active_cell_d [NCELL];
    logic [RSW-1:0]        shadow_rsel_q [NRES];
    logic [RSW-1:0]        shadow_rsel_d [NRES];
    logic [RSW-1:0]        active_rsel_q [NRES];
    logic [RSW-1:0]        active_rsel_d [NRES];

    commit_state_e         state_q;
    commit_state_e         state_d;
    logic                  stall;
    logic                  accept;
    logic                  pipe_empty;
    logic                  do_copy;

    assign res_valid  = stage_vld_q[COLS-1];
    assign stall      = stage_vld_q[COLS-1] & ~res_ready;
    assign cfg_busy   = (state_q == ST_PEND);
    assign in_ready   = ~stall & ~cfg_busy;
    assign accept     = in_valid & in_ready;
    assign pipe_empty = ~|stage_vld_q;
    assign dbg_state  = (state_q == ST_PEND);

    // Cell grid: column 0 reads the input slots, later columns read the previous stage.
    for (genvar c = 0; c < COLS; c++) begin : g_col
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            localparam int unsigned IDX = r * COLS + c;
            if (c == 0) begin : g_first
                clb_pipe_cell #(.WIDTH(WIDTH), .NSRC(NIN)) u_cell (
                    .src    (in_data),
                    .sel0   (active_cell_q[IDX].sel0[SELW-1:0]),
                    .sel1   (active_cell_q[IDX].sel1[SELW-1:0]),
                    .bypass (active_cell_q[IDX].bypass),
                    .op     (active_cell_q[IDX].op),
                    .y      (cell_y[c][r])
                );
            end else begin : g_next
                clb_pipe_cell #(.WIDTH(WIDTH), .NSRC(ROWS)) u_cell (
                    .src    (stage_data_q[c-1]),
                    .sel0   (active_cell_q[IDX].sel0[RSW-1:0]),
                    .sel1   (active_cell_q[IDX].sel1[RSW-1:0]),
                    .bypass (active_cell_q[IDX].bypass),
                    .op     (active_cell_q[IDX].op),
                    .y      (cell_y[c][r])
                );
            end
        end
    end

    // Pack each column's cell outputs into one row-indexed vector.
    always_comb begin
        for (int c = 0; c < COLS; c++) begin
            col_out[c] = '0;
            for (int r = 0; r < ROWS; r++) begin
                col_out[c][r*WIDTH +: WIDTH] = cell_y[c][r];
            end
        end
    end

    // Result muxes pick rows of the last stage.
    always_comb begin
        res_data = '0;
        for (int k = 0; k < NRES; k++) begin
            res_data[k*WIDTH +: WIDTH] = WIDTH'(stage_data_q[COLS-1] >> (WIDTH * active_rsel_q[k]));
        end
    end

    // Pipeline advance: every stage moves one column unless the output is stalled.
    always_comb begin
        stage_vld_d = stage_vld_q;
        for (int c = 0; c < COLS; c++) begin
            stage_data_d[c] = stage_data_q[c];
        end
        if (!stall) begin
            stage_vld_d[0]  = accept;
            stage_data_d[0] = col_out[0];
            for (int c = 1; c < COLS; c++) begin
                stage_vld_d[c]  = stage_vld_q[c-1];
                stage_data_d[c] = col_out[c];
            end
        end
    end

    // Commit FSM: wait in PEND until the pipe has drained, then copy shadow to active.
    always_comb begin
        state_d = state_q;
        do_copy = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_commit) state_d = ST_PEND;
            end
            ST_PEND: begin
                if (pipe_empty) begin
                    do_copy = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Shadow writes, and the copy that picks up a write landing on the same edge.
    always_comb begin
        shadow_cell_d = shadow_cell_q;
        shadow_rsel_d = shadow_rsel_q;
        active_cell_d = active_cell_q;
        active_rsel_d = active_rsel_q;
        for (int i = 0; i < NCELL; i++) begin
            if (cfg_we && (int'(cfg_addr) == i)) begin
                shadow_cell_d[i] = cell_cfg_unpack(CFG_MAXW'(cfg_data), SELW);
            end
        end
        for (int k = 0; k < NRES; k++) begin
            if (cfg_we && (int'(cfg_addr) == NCELL + k)) begin
                shadow_rsel_d[k] = cfg_data[RSW-1:0];
            end
        end
        if (do_copy) begin
            active_cell_d = shadow_cell_d;
            active_rsel_d = shadow_rsel_d;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            stage_vld_q <= '0;
            for (int c = 0; c < COLS; c++) stage_data_q[c] <= '0;
            for (int i = 0; i < NCELL; i++) begin
                shadow_cell_q[i] <= '0;
                active_cell_q[i] <= '0;
            end
            for (int k = 0; k < NRES; k++) begin
                shadow_rsel_q[k] <= '0;
                active_rsel_q[k] <= '0;
            end
        end else begin
            state_q       <= state_d;
            stage_vld_q   <= stage_vld_d;
            stage_data_q  <= stage_data_d;
            shadow_cell_q <= shadow_cell_d;
            active_cell_q <= active_cell_d;
            shadow_rsel_q <= shadow_rsel_d;
            active_rsel_q <= active_rsel_d;
        end
    end

endmodule

// File: tb/tb_clb_pipe_array.sv
// Directed bench for clb_pipe_array (WIDTH=32, ROWS=4, COLS=4, NRES=3).
// Config word: [2:0] sel0, [5:3] sel1, [7:6] op, [8] bypass; cell (r,c) at r*4+c,
// result mux k at 16+k. Results are packed {r2, r1, r0}.
module tb_clb_pipe_array;

    localparam int W     = 32;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int NRES  = 3;
    localparam int NIN   = 2 * ROWS;
    localparam int ADDRW = 5;
    localparam int CFGW  = 9;

    logic                 clk;
    logic                 rst_n;
    logic [NIN*W-1:0]     in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [NRES*W-1:0]    res_data;
    logic                 res_valid;
    logic                 res_ready;
    logic                 cfg_we;
    logic [ADDRW-1:0]     cfg_addr;
    logic [CFGW-1:0]      cfg_data;
    logic                 cfg_commit;
    logic                 cfg_busy;
    logic                 dbg_state;

    int                   n_vec = 0;
    int                   n_err = 0;
    logic [NRES*W-1:0]    exp_q [$];
    logic                 toggle_en = 1'b0;
    int                   rdy_idx = 0;

    clb_pipe_array #(.WIDTH(W), .ROWS(ROWS), .COLS(COLS), .NRES(NRES)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .cfg_commit (cfg_commit),
        .cfg_busy   (cfg_busy),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    // ---------------- helpers ----------------
    function automatic logic [NIN*W-1:0] make_in(input logic [W-1:0] s0,
                                                 input logic [W-1:0] s1,
                                                 input logic [W-1:0] fill);
        logic [NIN*W-1:0] v;
        for (int i = 0; i < NIN; i++) v[i*W +: W] = fill;
        v[0 +: W] = s0;
        v[W +: W] = s1;
        return v;
    endfunction

    function automatic logic [NRES*W-1:0] make_res(input logic [W-1:0] r0,
                                                   input logic [W-1:0] r1,
                                                   input logic [W-1:0] r2);
        return {r2, r1, r0};
    endfunction

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic check_res(input string name, input logic [NRES*W-1:0] act,
                             input logic [NRES*W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks (called at posedge + 1) ----------------
    task automatic send(input logic [NIN*W-1:0] d, input logic [NRES*W-1:0] e,
                        input logic with_commit);
        logic accepted;
        accepted   = 1'b0;
        in_data    = d;
        in_valid   = 1'b1;
        cfg_commit = with_commit;
        for (int i = 0; i < 100 && !accepted; i++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid   = 1'b0;
        cfg_commit = 1'b0;
        if (!accepted) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got in_ready=0 for 100 cycles, required acceptance");
        end
    endtask

    task automatic write_cfg(input logic [ADDRW-1:0] a, input logic [CFGW-1:0] d);
        cfg_we   = 1'b1;
        cfg_addr = a;
        cfg_data = d;
        @(posedge clk);
        #1;
        cfg_we   = 1'b0;
    endtask

    // Commit on an empty pipe: busy for exactly one cycle.
    task automatic do_commit();
        cfg_commit = 1'b1;
        @(negedge clk);
        check_bit("commit_busy_before", cfg_busy, 1'b0);
        @(posedge clk);
        #1;
        cfg_commit = 1'b0;
        @(negedge clk);
        check_bit("commit_busy_pend", cfg_busy, 1'b1);
        check_bit("commit_ready_pend", in_ready, 1'b0);
        check_bit("commit_dbg_state", dbg_state, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_bit("commit_busy_done", cfg_busy, 1'b0);
        check_bit("commit_ready_done", in_ready, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: got %0d results outstanding, required 0", exp_q.size());
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // ---------------- consumer ready pattern 1,0,0,1 ----------------
    initial begin
        res_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (toggle_en) begin
                case (rdy_idx % 4)
                    0, 3:    res_ready = 1'b1;
                    default: res_ready = 1'b0;
                endcase
                rdy_idx++;
            end else begin
                res_ready = 1'b1;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && res_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL res_unexpected: got %h required no result", res_data);
                end else begin
                    check_res("res_data", res_data, exp_q[0]);
                    if (res_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_data   = '0;
        cfg_commit = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_bit("reset_res_valid", res_valid, 1'b0);
        check_bit("reset_cfg_busy", cfg_busy, 1'b0);
        check_bit("reset_in_ready", in_ready, 1'b1);
        check_bit("reset_dbg_state", dbg_state, 1'b0);
        check_res("reset_res_data", res_data, '0);
        @(posedge clk);
        #1;

        // Default config: each column doubles row 0 -> 5*16 = 80, plus latency check.
        send(make_in(5, 5, 5), make_res(80, 80, 80), 1'b0);
        for (int i = 0; i < COLS - 1; i++) begin
            @(negedge clk);
            check_bit("latency_not_yet", res_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check_bit("latency_arrive", res_valid, 1'b1);
        @(posedge clk);
        #1;
        wait_drain();

        // cell(0,0) = slot0 - slot1, row 0 of columns 1..3 bypass, result 1 = row 1.
        write_cfg(5'd0, 9'h048);
        write_cfg(5'd1, 9'h100);
        write_cfg(5'd2, 9'h100);
        write_cfg(5'd3, 9'h100);
        write_cfg(5'd17, 9'h001);
        do_commit();
        send(make_in(10, 3, 0), make_res(7, 14, 7), 1'b0);
        wait_drain();

        // Back-to-back stream under backpressure: r0 = 9i+20, r1 = 2*r0.
        toggle_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(make_in(10 * i + 20, i, 0),
                 make_res(9 * i + 20, 2 * (9 * i + 20), 9 * i + 20), 1'b0);
        end
        wait_drain();
        toggle_en = 1'b0;
        @(posedge clk);
        #1;

        // Wraparound: 0xFFFFFFFF + 2 = 1, passed through the bypass chain.
        write_cfg(5'd0, 9'h008);
        do_commit();
        send(make_in(32'hFFFF_FFFF, 2, 0), make_res(1, 2, 1), 1'b0);
        wait_drain();

        // Shadow cell(0,0) := XOR; commit arrives with the third in-flight beat.
        write_cfg(5'd0, 9'h0C8);
        send(make_in(1, 2, 0), make_res(3, 6, 3), 1'b0);
        send(make_in(5, 6, 0), make_res(11, 22, 11), 1'b0);
        send(make_in(16, 32, 0), make_res(48, 96, 48), 1'b1);
        for (int i = 0; i < COLS + 1; i++) begin
            @(negedge clk);
            check_bit("drain_busy", cfg_busy, 1'b1);
            check_bit("drain_in_ready", in_ready, 1'b0);
            @(posedge clk);
            #1;
            if (i == COLS - 1) begin
                // Lands on the copy edge, so result 0 switches to row 1 too.
                cfg_we   = 1'b1;
                cfg_addr = 5'd16;
                cfg_data = 9'd1;
            end
        end
        cfg_we = 1'b0;
        @(negedge clk);
        check_bit("drain_busy_clear", cfg_busy, 1'b0);
        check_bit("drain_in_ready_back", in_ready, 1'b1);
        @(posedge clk);
        #1;
        send(make_in(6, 3, 0), make_res(10, 10, 5), 1'b0);
        wait_drain();

        // Reset mid-stream and mid-PEND with a pending shadow change.
        write_cfg(5'd0, 9'h100);
        send(make_in(7, 1, 0), make_res(12, 12, 6), 1'b0);
        send(make_in(7, 1, 0), make_res(12, 12, 6), 1'b0);
        send(make_in(7, 1, 0), make_res(12, 12, 6), 1'b0);
        send(make_in(7, 1, 0), make_res(12, 12, 6), 1'b1);
        @(negedge clk);
        check_bit("pre_reset_busy", cfg_busy, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
        @(negedge clk);
        check_bit("mid_reset_res_valid", res_valid, 1'b0);
        check_bit("mid_reset_cfg_busy", cfg_busy, 1'b0);
        check_bit("mid_reset_in_ready", in_ready, 1'b1);
        check_res("mid_reset_res_data", res_data, '0);
        @(posedge clk);
        #1;
        send(make_in(5, 5, 5), make_res(80, 80, 80), 1'b0);
        wait_drain();
        do_commit();
        send(make_in(5, 5, 5), make_res(80, 80, 80), 1'b0);
        wait_drain();

        check_bit("queue_empty", exp_q.size() == 0, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clb_pipe_array.md
# clb_pipe_array

Parametrised, pipelined successor to the 4x4 combinational CLB matrix. It holds a ROWS x COLS grid of ALU cells with one register stage per column, and a valid/ready stream handshake with backpressure. Its configuration is double-buffered and committed only after the pipeline drains. It sits between the operand source and the consumer of the NRES selected results.

## Interface
Parameters:
- WIDTH, 32, datapath width
- ROWS, 4, cells per column (power of 2, ≥2)
- COLS, 4, columns = pipeline stages (≥1)
- NRES, 3, result outputs (≥1)
- Derived: NIN=2*ROWS; SELW=clog2(NIN); CFGW=2*SELW+3; ADDRW=clog2(ROWS*COLS+NRES)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock, synchronous, active-low
- in_data  in  NIN*WIDTH  operand vector; slot i = bits [i*WIDTH +: WIDTH]
- in_valid  in  1  operand vector valid
- in_ready  out  1  block accepts in_data this cycle
- res_data  out  NRES*WIDTH  selected results
- res_valid  out  1  res_data valid
- res_ready  in  1  consumer accepts
- cfg_we  in  1  shadow config write strobe
- cfg_addr  in  ADDRW  0..ROWS*COLS-1 = cell r*COLS+c; ROWS*COLS+k = result mux k
- cfg_data  in  CFGW  cell: {bypass, op[1:0], sel1, sel0}; result mux: low clog2(ROWS) bits
- cfg_commit  in  1  request shadow→active copy
- cfg_busy  out  1  commit pending

## Operation
- Cell (r,c): a = src[sel0], b = src[sel1].
  - Column 0 src = the NIN input slots.
  - Column c>0 src = the previous column's ROWS outputs, indexed with sel mod ROWS (MSB ignored).
- op: 00 a+b, 01 a-b, 10 a&b, 11 a^b. All modulo 2^WIDTH, no carry or flags. bypass=1 → output = a regardless of op.
- Result k = last-column row res_sel[k] output.
- Stall: stall = res_valid & ~res_ready. While stalled, every stage register and its valid hold. in_ready = ~stall & ~cfg_busy.
- A beat advances one column per non-stalled cycle. It enters on in_valid & in_ready.
- cfg_we writes shadow[cfg_addr] at the edge. Out-of-range addresses are ignored. Writes are allowed at any time, including while busy.
- Commit state machine:
  - IDLE→PEND on cfg_commit (cfg_busy=1 from the next cycle).
  - In PEND: no new beats accepted. When all stage valids = 0, copy active←shadow on that edge and return to IDLE.
  - cfg_commit while in PEND is ignored.
  - A cfg_we in the same cycle as the copy edge is included in the copy.
  - Beats already in flight always use the old active config.

## Timing
- Latency: a beat accepted at edge t appears at res_valid/res_data after edge t+COLS-1 (COLS register stages; result mux combinational from the last stage).
- Throughput: 1 beat/cycle when res_ready=1.
- res_data is stable while res_valid & ~res_ready.
- Minimum commit: cfg_commit at cycle t with an empty pipe → copy at edge t+1, cfg_busy high for one cycle, in_ready low for that cycle.
- Reset:
  - All stage valids 0, stage data 0, res_valid 0, res_data 0, cfg_busy 0, state IDLE.
  - Active and shadow configs all-zero (sel 0, ADD, no bypass, res_sel 0).
  - Reset mid-stream discards in-flight beats and any pending commit.
- Simultaneous cfg_commit and in_valid with busy=0: the beat is accepted and uses the old config. The commit then waits for it to drain.

## Structure
- Package clb_pipe_pkg holds:
  - op encodings OP_ADD/OP_SUB/OP_AND/OP_XOR
  - the cell config struct {bypass, op, sel1, sel0}
  - CFGW/SELW helper functions
- Sub-module clb_pipe_cell: combinational operand muxes plus ALU, parametrised on WIDTH and source count. The top generates the ROWS x COLS grid, stage registers, handshake and commit state machine.

## Test plan
- Reset, then default config; in_data slots all = 5 → after COLS cycles every result = 5<<(COLS) mod 2^WIDTH (5+5 doubled per column: 80 for COLS=4).
- Program cell(0,0) sel0=0, sel1=1, op SUB; set bypass for row 0 of columns 1..3; commit; slot0=10, slot1=3 → result mux 0 (res_sel=0) = 7.
- Stream 8 beats back-to-back with res_ready toggling 1,0,0,1… → no loss or duplication, order preserved, res_data held while stalled.
- Overflow: cell ADD with 0xFFFFFFFF + 2 under bypass-through → result 0x00000001.
- Commit with 3 beats in flight → cfg_busy=1 and in_ready=0 until drained; in-flight beats use the old config; the first new beat uses the new config.
- Assert rst_n low mid-stream and mid-PEND → next cycle res_valid=0, cfg_busy=0, and the config reads back as defaults (observed via a default-config beat).
